// File: rtl/kpscan_pkg.sv
// Shared types and helpers for the kpscan keypad front end.
// The auto-repeat option itself is selected in kpscan by KPSCAN_REPEAT_EN.
package kpscan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kpscan_state_t;

  localparam logic [3:0] COL_FIRST = 4'b1110;
  localparam logic [3:0] ROWS_NONE = 4'hF;

  // A pattern names a single key only when exactly one row is pulled low.
  function automatic logic one_low(input logic [3:0] rows);
    logic [3:0] low;
    low = ~rows;
    return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/kp_tick_gen.sv
// Free-running prescaler for the keypad scan: one-clk tick every DIV clocks.
module kp_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/kpscan.sv
// 4x4 keypad scanner: column drive, row synchronizer, press/release debounce.
// Define KPSCAN_REPEAT_EN to add auto-repeat pulses while a key is held.
//
// state    | meaning
// SCAN     | rotating the low column, waiting for a single-row hit
// DEBOUNCE | column frozen, counting ticks the hit stays identical
// HELD     | key accepted, kpr_out/key_down asserted
// RELEASE  | key looks gone, counting ticks before dropping it
module kpscan
  import kpscan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] kpr_out,
  output logic       key_down,
  output logic       key_pulse
);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("kpscan: SCAN_DIV and DEBOUNCE_CNT must be >= 2, repeat intervals >= 1");
  end

  localparam int KCNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [KCNT_W-1:0] KCNT_MAX  = KCNT_W'(DEBOUNCE_CNT);
  localparam logic [KCNT_W-1:0] KCNT_LAST = KCNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [KCNT_W-1:0] KCNT_ONE  = KCNT_W'(1);

  logic [3:0]        rs_meta;
  logic [3:0]        rs;
  logic [3:0]        ref_rows;
  logic              tick;
  logic              rs_match;
  kpscan_state_t     state;
  logic [KCNT_W-1:0] key_cnt;

`ifdef KPSCAN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_fire;

  assign rep_fire = (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_RATE_LAST));
`endif

  kp_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Rows are asynchronous to clk; only the second flop is looked at.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rs_meta <= ROWS_NONE;
      rs      <= ROWS_NONE;
    end else begin
      rs_meta <= kpr;
      rs      <= rs_meta;
    end
  end

  assign rs_match = (rs == ref_rows);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SCAN;
      kpc       <= COL_FIRST;
      kpr_out   <= ROWS_NONE;
      key_down  <= 1'b0;
      key_pulse <= 1'b0;
      key_cnt   <= '0;
      ref_rows  <= ROWS_NONE;
`ifdef KPSCAN_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      key_pulse <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (one_low(rs)) begin
              state    <= DEBOUNCE;
              key_cnt  <= KCNT_ONE;
              ref_rows <= rs;
            end else begin
              kpc <= {kpc[2:0], kpc[3]};
            end
          end
          DEBOUNCE: begin
            if (!rs_match) begin
              state   <= SCAN;
              key_cnt <= '0;
            end else if (key_cnt >= KCNT_LAST) begin
              state     <= HELD;
              key_cnt   <= KCNT_MAX;
              kpr_out   <= ref_rows;
              key_down  <= 1'b1;
              key_pulse <= 1'b1;
`ifdef KPSCAN_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
`endif
            end else begin
              key_cnt <= key_cnt + 1'b1;
            end
          end
          HELD: begin
            if (!rs_match) begin
              state   <= RELEASE;
              key_cnt <= KCNT_ONE;
`ifdef KPSCAN_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
            end else if (rep_fire) begin
              key_pulse <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
`endif
            end
          end
          RELEASE: begin
            if (rs_match) begin
              // Bounce on release: back to HELD without a fresh press event.
              state   <= HELD;
              key_cnt <= '0;
`ifdef KPSCAN_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
`endif
            end else if (key_cnt >= KCNT_LAST) begin
              state    <= SCAN;
              key_cnt  <= '0;
              kpr_out  <= ROWS_NONE;
              key_down <= 1'b0;
            end else begin
              key_cnt <= key_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kpscan.sv
// Scoreboard bench for kpscan: keypad model, tick-level reference model, event monitor.
module tb_kpscan;

  localparam int DIV  = 4;
  localparam int DCNT = 3;
  localparam int RD   = 5;
  localparam int RR   = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] kpr_out;
  logic       key_down;
  logic       key_pulse;

  always #5 clk = ~clk;

  kpscan #(
    .SCAN_DIV     (DIV),
    .DEBOUNCE_CNT (DCNT),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kpr       (kpr),
    .kpc       (kpc),
    .kpr_out   (kpr_out),
    .key_down  (key_down),
    .key_pulse (key_pulse)
  );

  // Physical keypad: a pressed key pulls its row low only while its column is driven low.
  int   key_row = 0;
  int   key_col = 0;
  logic key_on  = 1'b0;
  logic ghost   = 1'b0;

  always_comb begin
    kpr = 4'hF;
    if (ghost) kpr = 4'b0011;
    else if (key_on && !kpc[key_col]) kpr = ~(4'b0001 << key_row);
  end

  function automatic logic [3:0] pat(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return ~v;
  endfunction

  int   phase = 0;
  int   cyc = 0;
  logic rst_d = 1'b0;

  always @(posedge clk) begin
    rst_d <= reset_n;
    phase <= reset_n ? (phase + 1) % DIV : 0;
    cyc   <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t pulse_q[$];
  exp_t rel_q[$];

  // Reference model: on each scan tick, look at what the rows show and apply the
  // run-length rules (DCNT identical single-row samples accept, DCNT differing ones release).
  int         m_run = 0;
  int         m_rel = 0;
  int         m_rep = 0;
  logic       m_held = 1'b0;
  logic       m_first = 1'b1;
  logic [3:0] m_ref = 4'hF;

  always @(negedge clk) begin
    logic [3:0] p;
    if (!reset_n || !rst_d) begin
      m_run = 0; m_rel = 0; m_rep = 0; m_held = 1'b0; m_first = 1'b1;
    end else if (phase == DIV - 1) begin
      p = kpr;
      if (!m_held) begin
        if (m_run > 0) begin
          if (p == m_ref) m_run++;
          else m_run = 0;
        end else if ($countones(~p) == 1) begin
          m_run = 1;
          m_ref = p;
        end
        if (m_run == DCNT) begin
          m_held = 1'b1; m_rel = 0; m_rep = 0; m_first = 1'b1;
          pulse_q.push_back('{{pat(key_row), pat(key_col)}, cyc + 1});
        end
      end else if (p == m_ref) begin
        if (m_rel > 0) begin
          m_rel = 0; m_rep = 0; m_first = 1'b1;
        end else begin
`ifdef KPSCAN_REPEAT_EN
          m_rep++;
          if (m_rep == (m_first ? RD : RR)) begin
            m_rep = 0; m_first = 1'b0;
            pulse_q.push_back('{{pat(key_row), pat(key_col)}, cyc + 1});
          end
`endif
        end
      end else begin
        m_rel++;
        m_rep = 0;
        if (m_rel == DCNT) begin
          m_held = 1'b0; m_run = 0; m_rel = 0;
          rel_q.push_back('{8'hFF, cyc + 1});
        end
      end
    end
  end

  // Monitor: every key_pulse and every key_down fall must match a queued expectation.
  logic prev_kd = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (key_pulse) begin
      if (pulse_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pulse: got pulse with {kpr_out,kpc}=%b, expected none (t=%0t)",
                 {kpr_out, kpc}, $time);
      end else begin
        e = pulse_q.pop_front();
        check("pulse_time", cyc, e.due);
        check("pulse_key", {kpr_out, kpc}, e.data);
        check("pulse_down", key_down, 1'b1);
      end
    end else if (pulse_q.size() > 0 && pulse_q[0].due < cyc) begin
      e = pulse_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL missing_pulse: got none at cyc %0d, expected key %b", e.due, e.data);
    end
    if (prev_kd && !key_down && rst_d) begin
      if (rel_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_release: got key_down fall, expected none (t=%0t)", $time);
      end else begin
        e = rel_q.pop_front();
        check("release_time", cyc, e.due);
        check("release_rows", kpr_out, 4'hF);
      end
    end else if (rel_q.size() > 0 && rel_q[0].due < cyc) begin
      e = rel_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL missing_release: got key_down=%b at cyc %0d, expected fall", key_down, e.due);
    end
    prev_kd = key_down;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (phase != 0) @(negedge clk);
    end
  endtask

  task automatic wait_down(input logic lvl, input int max_ticks, input string name);
    int n = 0;
    while (key_down !== lvl && n < max_ticks * DIV) begin
      @(negedge clk);
      n++;
    end
    check(name, key_down, lvl);
  endtask

  task automatic wait_col(input int col);
    bit ok = 0;
    for (int i = 0; i < 16 && !ok; i++) begin
      wait_ticks(1);
      if (kpc == pat(col)) ok = 1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL col_timeout: got kpc=%b, expected %b", kpc, pat(col));
    end
  endtask

  task automatic pick_key();
    key_row = int'($urandom_range(0, 3));
    key_col = int'($urandom_range(0, 3));
  endtask

  task automatic clean_press(input int hold);
    wait_ticks(1);
    key_on = 1'b1;
    wait_ticks(hold);
    key_on = 1'b0;
    wait_ticks(DCNT + 3);
    check("clean_released", key_down, 1'b0);
  endtask

  task automatic key5();
    key_row = 2; key_col = 2;
    wait_ticks(1);
    key_on = 1'b1;
    wait_down(1'b1, 12, "key5_down");
    check("key5_pair", {kpr_out, kpc}, 8'b10111011);
    wait_ticks(4);
    check("key5_frozen", kpc, 4'b1011);
    key_on = 1'b0;
    wait_ticks(DCNT + 3);
    check("key5_rows_idle", kpr_out, 4'hF);
  endtask

  task automatic press_bounce();
    pick_key();
    wait_col(key_col);
    key_on = 1'b1;
    wait_ticks(1);
    key_on = 1'b0;
    wait_ticks(1);
    check("pb_not_yet", key_down, 1'b0);
    key_on = 1'b1;
    wait_ticks(DCNT + 2);
    check("pb_down", key_down, 1'b1);
    key_on = 1'b0;
    wait_ticks(DCNT + 3);
  endtask

  task automatic release_bounce();
    pick_key();
    wait_ticks(1);
    key_on = 1'b1;
    wait_down(1'b1, 12, "rb_down");
    wait_ticks(1);
    key_on = 1'b0;
    wait_ticks(1);
    key_on = 1'b1;
    wait_ticks(1);
    key_on = 1'b0;
    wait_ticks(2);
    check("rb_still_down", key_down, 1'b1);
    wait_ticks(1);
    check("rb_dropped", key_down, 1'b0);
    check("rb_rows_idle", kpr_out, 4'hF);
    wait_ticks(1);
    check("rb_scan_resumed", kpc, pat((key_col + 1) % 4));
  endtask

  task automatic ghost_test();
    wait_ticks(1);
    ghost = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(1);
      check("ghost_down", key_down, 1'b0);
      check("ghost_rows", kpr_out, 4'hF);
    end
    ghost = 1'b0;
    wait_ticks(2);
  endtask

  task automatic reset_test();
    pick_key();
    wait_ticks(1);
    key_on = 1'b1;
    wait_down(1'b1, 12, "rst_held");
    wait_ticks(1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_kpc", kpc, 4'b1110);
    check("rst_rows", kpr_out, 4'hF);
    check("rst_down", key_down, 1'b0);
    reset_n = 1'b1;
    wait_ticks(12);
    key_on = 1'b0;
    wait_ticks(DCNT + 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cols [4];
    cols[0] = 4'b1110; cols[1] = 4'b1101; cols[2] = 4'b1011; cols[3] = 4'b0111;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_kpc", kpc, 4'b1110);
    check("reset_rows", kpr_out, 4'hF);
    check("reset_down", key_down, 1'b0);
    check("reset_pulse", key_pulse, 1'b0);
    reset_n = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("idle_kpc", kpc, cols[(k / DIV) % 4]);
    end
    check("idle_rows", kpr_out, 4'hF);

    key5();
    press_bounce();
    release_bounce();
    ghost_test();
    reset_test();

    for (int ep = 0; ep < 10; ep++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin pick_key(); clean_press(int'($urandom_range(9, 16))); end
        1: press_bounce();
        2: release_bounce();
        default: ghost_test();
      endcase
      wait_ticks(int'($urandom_range(1, 4)));
    end

    wait_ticks(6);
    check("pulse_queue_drained", pulse_q.size(), 0);
    check("release_queue_drained", rel_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
